// File: rtl/serial_reg_master.sv
// Byte-stream to 32-bit register-bus master: parses host frames from the buart rx side,
// runs one register transaction and streams the ACK/NAK or read-echo response back out.
module serial_reg_master #(
  parameter int unsigned BYTE_TIMEOUT = 1_000_000,
  parameter int unsigned BUS_TIMEOUT  = 255,
  parameter logic [7:0]  ACK_BYTE     = 8'hAC,
  parameter logic [7:0]  NAK_BYTE     = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        busy,
  output logic        err_timeout,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a byte is taken when rx_valid=1 outside the two-cycle shadow of the previous
  // rx_rd pulse; a byte is sent by a one-cycle tx_wr only when tx_busy=0 and two cycles have
  // passed since the previous tx_wr; reg_wr/reg_rd stay high until reg_ack=1 or timeout.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_BUS_WR   = 3'd3,
    S_BUS_RD   = 3'd4,
    S_SEND     = 3'd5
  } state_t;

  localparam logic [19:0] BYTE_LAST = 20'(BYTE_TIMEOUT - 1);
  localparam logic [7:0]  BUS_LAST  = 8'(BUS_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  idx_q, idx_d;
  logic        rx_rd_q, rx_rd_d;
  logic        rx_hold_q, rx_hold_d;
  logic [19:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  bus_cnt_q, bus_cnt_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic        nak_q, nak_d;
  logic        tx_wr_q, tx_wr_d;
  logic        tx_gap_q, tx_gap_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        err_q, err_d;

  logic        rx_take;
  logic [2:0]  resp_len;
  logic [7:0]  resp_byte;

  always_comb begin
    resp_len  = (nak_q || !cmd_q[7]) ? 3'd1 : 3'd6;
    resp_byte = ACK_BYTE;
    if (nak_q) begin
      resp_byte = NAK_BYTE;
    end else if (cmd_q[7]) begin
      case (tx_idx_q)
        3'd0:    resp_byte = cmd_q;
        3'd1:    resp_byte = addr_q;
        3'd2:    resp_byte = rdata_q[7:0];
        3'd3:    resp_byte = rdata_q[15:8];
        3'd4:    resp_byte = rdata_q[23:16];
        default: resp_byte = rdata_q[31:24];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    idx_d      = idx_q;
    rx_rd_d    = 1'b0;
    rx_hold_d  = rx_rd_q;
    byte_cnt_d = byte_cnt_q;
    bus_cnt_d  = bus_cnt_q;
    reg_wr_d   = reg_wr_q;
    reg_rd_d   = reg_rd_q;
    nak_d      = nak_q;
    tx_wr_d    = 1'b0;
    tx_gap_d   = tx_wr_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;
    err_d      = 1'b0;
    // buart drops rx_valid one cycle after seeing rx_rd, so the stale flag is masked twice
    rx_take    = rx_valid && !rx_rd_q && !rx_hold_q;

    case (state_q)
      S_IDLE: begin
        if (rx_take) begin
          cmd_d      = rx_data;
          rx_rd_d    = 1'b1;
          byte_cnt_d = '0;
          state_d    = S_GET_ADDR;
        end
      end
      S_GET_ADDR: begin
        if (rx_take) begin
          addr_d     = rx_data;
          rx_rd_d    = 1'b1;
          byte_cnt_d = '0;
          idx_d      = '0;
          bus_cnt_d  = '0;
          state_d    = cmd_q[7] ? S_BUS_RD : S_GET_DATA;
        end else if (byte_cnt_q == BYTE_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + 20'd1;
        end
      end
      S_GET_DATA: begin
        if (rx_take) begin
          // little-endian: shifting in from the top leaves the first byte in [7:0]
          wdata_d    = {rx_data, wdata_q[31:8]};
          rx_rd_d    = 1'b1;
          byte_cnt_d = '0;
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_BUS_WR;
          end
        end else if (byte_cnt_q == BYTE_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + 20'd1;
        end
      end
      S_BUS_WR, S_BUS_RD: begin
        if (!reg_wr_q && !reg_rd_q) begin
          reg_wr_d  = (state_q == S_BUS_WR);
          reg_rd_d  = (state_q == S_BUS_RD);
          bus_cnt_d = '0;
        end else if (reg_ack) begin
          reg_wr_d = 1'b0;
          reg_rd_d = 1'b0;
          rdata_d  = reg_rdata;
          nak_d    = 1'b0;
          tx_idx_d = '0;
          state_d  = S_SEND;
        end else if (bus_cnt_q == BUS_LAST) begin
          reg_wr_d = 1'b0;
          reg_rd_d = 1'b0;
          err_d    = 1'b1;
          nak_d    = 1'b1;
          tx_idx_d = '0;
          state_d  = S_SEND;
        end else begin
          bus_cnt_d = bus_cnt_q + 8'd1;
        end
      end
      S_SEND: begin
        if (!tx_wr_q && !tx_gap_q) begin
          if (tx_idx_q == resp_len) begin
            state_d = S_IDLE;
          end else if (!tx_busy) begin
            tx_wr_d   = 1'b1;
            tx_data_d = resp_byte;
            tx_idx_d  = tx_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      idx_q      <= '0;
      rx_rd_q    <= 1'b0;
      rx_hold_q  <= 1'b0;
      byte_cnt_q <= '0;
      bus_cnt_q  <= '0;
      reg_wr_q   <= 1'b0;
      reg_rd_q   <= 1'b0;
      nak_q      <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_gap_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_idx_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      idx_q      <= idx_d;
      rx_rd_q    <= rx_rd_d;
      rx_hold_q  <= rx_hold_d;
      byte_cnt_q <= byte_cnt_d;
      bus_cnt_q  <= bus_cnt_d;
      reg_wr_q   <= reg_wr_d;
      reg_rd_q   <= reg_rd_d;
      nak_q      <= nak_d;
      tx_wr_q    <= tx_wr_d;
      tx_gap_q   <= tx_gap_d;
      tx_data_q  <= tx_data_d;
      tx_idx_q   <= tx_idx_d;
      err_q      <= err_d;
    end
  end

  assign rx_rd       = rx_rd_q;
  assign tx_wr       = tx_wr_q;
  assign tx_data     = tx_data_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_reg_master.sv
// Directed bench for serial_reg_master: buart rx/tx models, a register-bus responder backed
// by a small register array, and an expected-byte queue for the transmitted responses.
module tb_serial_reg_master;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        tx_busy;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        busy;
  logic        err_timeout;
  logic [2:0]  dbg_state;

  serial_reg_master #(
    .BYTE_TIMEOUT(1000),
    .BUS_TIMEOUT (255),
    .ACK_BYTE    (8'hAC),
    .NAK_BYTE    (8'hEE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .tx_busy    (tx_busy),
    .tx_wr      (tx_wr),
    .tx_data    (tx_data),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack),
    .busy       (busy),
    .err_timeout(err_timeout),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] model[256];

  int cyc = 0, last_rd_cyc = 0, err_cyc = 0, last_tx_cyc = -100;
  int err_cnt = 0, wr_starts = 0, rd_starts = 0, wr_cycles = 0, rd_cycles = 0, unstable = 0;
  int ack_delay = 3;
  logic [7:0]  cap_addr;
  logic [31:0] cap_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // buart models, bus responder and protocol monitor, all evaluated mid-cycle
  initial begin
    int stale = 0;
    int bstart = 0;
    int bcnt = 0;
    int n = 0;
    logic req_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      chk("strobe_overlap", 32'((rx_rd | tx_wr) & (reg_wr | reg_rd)), 32'd0);
      if (err_timeout) begin err_cnt++; err_cyc = cyc; end
      if (rx_rd) last_rd_cyc = cyc;
      if ((reg_wr | reg_rd) && !req_prev) begin
        cap_addr = reg_addr; cap_wdata = reg_wdata;
        if (reg_wr) wr_starts++; else rd_starts++;
      end else if (reg_wr | reg_rd) begin
        if (reg_addr !== cap_addr || reg_wdata !== cap_wdata) unstable++;
      end
      if (reg_wr) wr_cycles++;
      if (reg_rd) rd_cycles++;
      req_prev = reg_wr | reg_rd;
      if (tx_wr) begin
        chk("tx_busy_at_wr", 32'(tx_busy), 32'd0);
        chk("tx_guard", 32'((cyc - last_tx_cyc) >= 3), 32'd1);
        got_q.push_back(tx_data);
        last_tx_cyc = cyc;
      end
      // transmitter reports busy two mid-cycles after the strobe, then stays busy for a while
      if (bstart == 1) begin tx_busy = 1'b1; bcnt = 6; bstart = 0; end
      else if (bstart > 1) bstart--;
      else if (bcnt > 0) begin bcnt--; if (bcnt == 0) tx_busy = 1'b0; end
      if (tx_wr) bstart = 2;
      // receiver keeps the consumed byte's valid visible briefly before updating
      if (rx_rd) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        stale = 2;
      end else if (stale > 0) stale--;
      if (stale == 0) begin
        rx_valid = (rx_q.size() > 0);
        if (rx_q.size() > 0) rx_data = rx_q[0];
      end
      // register decoder
      if (reg_ack) begin
        reg_ack = 1'b0; n = 0;
      end else if (reg_wr | reg_rd) begin
        n++;
        if (ack_delay > 0 && n == ack_delay) begin
          if (reg_wr) model[reg_addr] = reg_wdata;
          else reg_rdata = model[reg_addr];
          reg_ack = 1'b1;
        end
      end else n = 0;
    end
  end

  // driver tasks
  task automatic send_write(input logic [7:0] a, input logic [31:0] d);
    rx_q.push_back(8'h01); rx_q.push_back(a);
    rx_q.push_back(d[7:0]); rx_q.push_back(d[15:8]);
    rx_q.push_back(d[23:16]); rx_q.push_back(d[31:24]);
  endtask

  task automatic send_read(input logic [7:0] c, input logic [7:0] a);
    rx_q.push_back(c); rx_q.push_back(a);
  endtask

  task automatic exp_read(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back(c); exp_q.push_back(a);
    exp_q.push_back(d[7:0]); exp_q.push_back(d[15:8]);
    exp_q.push_back(d[23:16]); exp_q.push_back(d[31:24]);
  endtask

  // scoreboard: wait for the expected number of bytes and idle, then compare in order
  task automatic check_tx(input string tag);
    int t = 0;
    while ((got_q.size() < exp_q.size() || busy || rx_q.size() > 0) && t < 6000) begin
      @(negedge clk); t++;
    end
    chk({tag, "_done"}, 32'(t < 6000), 32'd1);
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int w0, r0, wc0, rc0, e0, t;
    for (int i = 0; i < 256; i++) model[i] = '0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0;
    reg_rdata = '0; reg_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({rx_rd, tx_wr, reg_wr, reg_rd, err_timeout}), 32'd0);
    chk("rst_data", {reg_addr, tx_data, 16'd0}, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single write, ack after 3 cycles
    w0 = wr_starts; wc0 = wr_cycles; e0 = err_cnt; ack_delay = 3;
    send_write(8'h10, 32'h11223344);
    exp_q.push_back(8'hAC);
    check_tx("wr1");
    chk("wr1_starts", 32'(wr_starts - w0), 32'd1);
    chk("wr1_cycles", 32'(wr_cycles - wc0), 32'd3);
    chk("wr1_addr", 32'(cap_addr), 32'h10);
    chk("wr1_wdata", cap_wdata, 32'h11223344);
    chk("wr1_model", model[8'h10], 32'h11223344);
    chk("wr1_err", 32'(err_cnt - e0), 32'd0);

    // read with echo
    model[8'h10] = 32'hDEADBEEF; r0 = rd_starts;
    send_read(8'h81, 8'h10);
    exp_read(8'h81, 8'h10, 32'hDEADBEEF);
    check_tx("rd1");
    chk("rd1_starts", 32'(rd_starts - r0), 32'd1);

    // bus timeout on write and read
    ack_delay = 0; wc0 = wr_cycles; rc0 = rd_cycles; e0 = err_cnt;
    send_write(8'h20, 32'h55667788);
    exp_q.push_back(8'hEE);
    check_tx("wr_to");
    chk("wr_to_cycles", 32'(wr_cycles - wc0), 32'd255);
    chk("wr_to_err", 32'(err_cnt - e0), 32'd1);
    send_read(8'h81, 8'h20);
    exp_q.push_back(8'hEE);
    check_tx("rd_to");
    chk("rd_to_cycles", 32'(rd_cycles - rc0), 32'd255);
    chk("rd_to_err", 32'(err_cnt - e0), 32'd2);

    // ack arriving in the last allowed cycle still succeeds
    ack_delay = 255; wc0 = wr_cycles; e0 = err_cnt;
    send_write(8'h30, 32'hCAFEF00D);
    exp_q.push_back(8'hAC);
    check_tx("wr_edge");
    chk("wr_edge_cycles", 32'(wr_cycles - wc0), 32'd255);
    chk("wr_edge_err", 32'(err_cnt - e0), 32'd0);
    chk("wr_edge_model", model[8'h30], 32'hCAFEF00D);

    // byte timeout mid-frame
    ack_delay = 3; w0 = wr_starts; e0 = err_cnt; t = 0;
    rx_q.push_back(8'h01); rx_q.push_back(8'h10); rx_q.push_back(8'h44);
    while (err_cnt == e0 && t < 3000) begin @(negedge clk); t++; end
    chk("bto_seen", 32'(err_cnt - e0), 32'd1);
    chk("bto_latency", 32'(err_cyc - last_rd_cyc), 32'd1000);
    @(negedge clk);
    chk("bto_idle", 32'(busy), 32'd0);
    chk("bto_no_tx", 32'(got_q.size()), 32'd0);
    chk("bto_no_wr", 32'(wr_starts - w0), 32'd0);
    send_write(8'h10, 32'hA5A50F0F);
    exp_q.push_back(8'hAC);
    check_tx("bto_next");
    chk("bto_next_model", model[8'h10], 32'hA5A50F0F);

    // reset in the middle of a read response
    model[8'h40] = 32'h01020304; t = 0;
    send_read(8'h81, 8'h40);
    while (got_q.size() < 2 && t < 3000) begin @(negedge clk); t++; end
    chk("rst_mid_reach", 32'(got_q.size()), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_strobes", 32'({rx_rd, tx_wr, reg_wr, reg_rd, err_timeout, busy}), 32'd0);
    chk("rst_mid_data", {reg_addr, tx_data, 16'd0}, 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_tx", 32'(got_q.size()), 32'd2);
    got_q.delete();
    send_read(8'h81, 8'h40);
    exp_read(8'h81, 8'h40, 32'h01020304);
    check_tx("rst_after");

    // back-to-back write then read of the same register
    send_write(8'h50, 32'h0BADF00D);
    send_read(8'h9A, 8'h50);
    exp_q.push_back(8'hAC);
    exp_read(8'h9A, 8'h50, 32'h0BADF00D);
    check_tx("b2b");
    chk("b2b_unstable", 32'(unstable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
